// File: rtl/eq_pkg.sv
// Shared constants and enums for the three-band gain mixer.
package eq_pkg;

    localparam int unsigned AUDIO_DEPTH = 16;
    localparam int unsigned GAIN_WIDTH  = 8;
    localparam int unsigned GAIN_FRAC   = 6;
    localparam int unsigned GAIN_UNITY  = 64;

    typedef enum logic [1:0] {
        BAND_LOW  = 2'd0,
        BAND_MID  = 2'd1,
        BAND_HIGH = 2'd2
    } band_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MAC_LOW  = 3'd1,
        MAC_MID  = 3'd2,
        MAC_HIGH = 3'd3,
        OUTPUT   = 3'd4
    } mix_state_e;

endpackage

// File: rtl/eq_sat.sv
// Reduces the scaled accumulator to the output sample width.
// EQ_MIX_SATURATE_EN defined: clamp to the signed output range; otherwise wrap.
module eq_sat #(
    parameter int unsigned IN_W  = 27,
    parameter int unsigned OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout_c
);

`ifdef EQ_MIX_SATURATE_EN
    localparam logic signed [IN_W-1:0]  MAX_IN  = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0]  MIN_IN  = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic signed [OUT_W-1:0] MAX_OUT = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] MIN_OUT = {1'b1, {(OUT_W-1){1'b0}}};

    always_comb begin
        dout_c = din[OUT_W-1:0];
        if (din > MAX_IN) begin
            dout_c = MAX_OUT;
        end else if (din < MIN_IN) begin
            dout_c = MIN_OUT;
        end
    end
`else
    // Upper bits are intentionally discarded in wrap mode.
    logic unused_hi_c;
    assign unused_hi_c = ^din[IN_W-1:OUT_W];

    always_comb begin
        dout_c = din[OUT_W-1:0];
    end
`endif

endmodule

// File: rtl/band_gain_mixer.sv
// Three-band gain mixer: sequential MAC of low/mid/high band times Q2.6 gain.
// Output reduction mode selected in eq_sat by EQ_MIX_SATURATE_EN.
module band_gain_mixer
    import eq_pkg::*;
#(
    parameter int unsigned AUDIO_DEPTH = eq_pkg::AUDIO_DEPTH,
    parameter int unsigned GAIN_WIDTH  = eq_pkg::GAIN_WIDTH,
    parameter int unsigned GAIN_FRAC   = eq_pkg::GAIN_FRAC
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sample_valid,
    input  logic signed [AUDIO_DEPTH-1:0] low_band,
    input  logic signed [AUDIO_DEPTH-1:0] mid_band,
    input  logic signed [AUDIO_DEPTH-1:0] high_band,
    input  logic                          gain_we,
    input  logic [1:0]                    gain_sel,
    input  logic [GAIN_WIDTH-1:0]         gain_data,
    output logic signed [AUDIO_DEPTH-1:0] audio_out,
    output logic                          out_valid,
    output logic                          busy,
    output logic                          sample_drop
);

    localparam int unsigned PROD_W = AUDIO_DEPTH + GAIN_WIDTH + 1;
    localparam int unsigned ACC_W  = PROD_W + 2;
    localparam logic [GAIN_WIDTH-1:0] UNITY = GAIN_WIDTH'(GAIN_UNITY);

    mix_state_e state_q, state_d;

    logic signed [AUDIO_DEPTH-1:0] band_q   [3];
    logic signed [AUDIO_DEPTH-1:0] band_d   [3];
    logic [GAIN_WIDTH-1:0]         shadow_q [3];
    logic [GAIN_WIDTH-1:0]         shadow_d [3];
    logic [GAIN_WIDTH-1:0]         active_q [3];
    logic [GAIN_WIDTH-1:0]         active_d [3];
    logic signed [ACC_W-1:0]       acc_q, acc_d;
    logic signed [AUDIO_DEPTH-1:0] audio_out_q, audio_out_d;
    logic                          out_valid_q, out_valid_d;
    logic                          busy_q, busy_d;
    logic                          sample_drop_q, sample_drop_d;

    logic signed [AUDIO_DEPTH-1:0] band_cur_c;
    logic [GAIN_WIDTH-1:0]         gain_cur_c;
    logic signed [PROD_W-1:0]      prod_c;
    logic signed [ACC_W-1:0]       result_c;
    logic signed [AUDIO_DEPTH-1:0] reduced_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (sample_valid) state_d = MAC_LOW;
            MAC_LOW:  state_d = MAC_MID;
            MAC_MID:  state_d = MAC_HIGH;
            MAC_HIGH: state_d = OUTPUT;
            OUTPUT:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Band/gain operand select for the current MAC step
    always_comb begin
        band_cur_c = band_q[BAND_LOW];
        gain_cur_c = active_q[BAND_LOW];
        case (state_q)
            MAC_MID: begin
                band_cur_c = band_q[BAND_MID];
                gain_cur_c = active_q[BAND_MID];
            end
            MAC_HIGH: begin
                band_cur_c = band_q[BAND_HIGH];
                gain_cur_c = active_q[BAND_HIGH];
            end
            default: ;
        endcase
    end

    // Gain is unsigned, so zero-extend before the signed multiply.
    assign prod_c   = PROD_W'(band_cur_c) * $signed(PROD_W'(gain_cur_c));
    assign result_c = acc_q >>> GAIN_FRAC;

    eq_sat #(
        .IN_W  (ACC_W),
        .OUT_W (AUDIO_DEPTH)
    ) u_sat (
        .din    (result_c),
        .dout_c (reduced_c)
    );

    // Output and datapath next values
    always_comb begin
        band_d        = band_q;
        shadow_d      = shadow_q;
        active_d      = active_q;
        acc_d         = acc_q;
        audio_out_d   = audio_out_q;
        out_valid_d   = 1'b0;
        busy_d        = (state_d != IDLE);
        sample_drop_d = sample_valid && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    band_d[BAND_LOW]  = low_band;
                    band_d[BAND_MID]  = mid_band;
                    band_d[BAND_HIGH] = high_band;
                    active_d          = shadow_q;
                    acc_d             = '0;
                end
            end
            MAC_LOW, MAC_MID, MAC_HIGH: begin
                acc_d = acc_q + ACC_W'(prod_c);
            end
            OUTPUT: begin
                audio_out_d = reduced_c;
                out_valid_d = 1'b1;
            end
            default: ;
        endcase

        // Shadow write lands after acceptance copied the old shadow values.
        if (gain_we) begin
            case (gain_sel)
                2'd0:    shadow_d[BAND_LOW]  = gain_data;
                2'd1:    shadow_d[BAND_MID]  = gain_data;
                2'd2:    shadow_d[BAND_HIGH] = gain_data;
                default: ;
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                band_q[i]   <= '0;
                shadow_q[i] <= UNITY;
                active_q[i] <= UNITY;
            end
            acc_q         <= '0;
            audio_out_q   <= '0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            sample_drop_q <= 1'b0;
        end else begin
            band_q        <= band_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            acc_q         <= acc_d;
            audio_out_q   <= audio_out_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
            sample_drop_q <= sample_drop_d;
        end
    end

    assign audio_out   = audio_out_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign sample_drop = sample_drop_q;

endmodule

// File: tb/tb_band_gain_mixer.sv
// Scoreboard bench for band_gain_mixer: driver feeds a reference model, monitor checks outputs.
module tb_band_gain_mixer;

    localparam int MAXE = 4000;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               sample_valid = 1'b0;
    logic signed [15:0] low_band = '0;
    logic signed [15:0] mid_band = '0;
    logic signed [15:0] high_band = '0;
    logic               gain_we = 1'b0;
    logic [1:0]         gain_sel = '0;
    logic [7:0]         gain_data = '0;
    logic signed [15:0] audio_out;
    logic               out_valid;
    logic               busy;
    logic               sample_drop;

    band_gain_mixer dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .low_band     (low_band),
        .mid_band     (mid_band),
        .high_band    (high_band),
        .gain_we      (gain_we),
        .gain_sel     (gain_sel),
        .gain_data    (gain_data),
        .audio_out    (audio_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .sample_drop  (sample_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        int due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   exp_set  [MAXE];
    bit   exp_busy [MAXE];
    bit   exp_drop [MAXE];
    bit   exp_rst  [MAXE];

    // Reference model state
    int m_gain [3];
    int m_acc_edge = -100;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int reduce(input longint q);
        longint r;
`ifdef EQ_MIX_SATURATE_EN
        if (q > 32767) r = 32767;
        else if (q < -32768) r = -32768;
        else r = q;
`else
        r = q % 65536;
        if (r < 0) r += 65536;
        if (r > 32767) r -= 65536;
`endif
        return int'(r);
    endfunction

    // Mixed sample: sum of band*gain, divided by 64 rounding toward -infinity.
    function automatic int mix(input int l, input int m, input int h);
        longint s, q;
        s = longint'(l) * m_gain[0] + longint'(m) * m_gain[1] + longint'(h) * m_gain[2];
        q = s / 64;
        if ((s % 64 != 0) && (s < 0)) q = q - 1;
        return reduce(q);
    endfunction

    // Drive one clock's worth of inputs and advance the model to the coming edge.
    task automatic drive(input bit rst, input bit sv, input int l, input int m, input int h,
                         input bit we, input int sel, input int dat);
        int  e;
        int  d;
        bit  was_busy;
        reset        = rst;
        sample_valid = sv;
        low_band     = 16'(l);
        mid_band     = 16'(m);
        high_band    = 16'(h);
        gain_we      = we;
        gain_sel     = 2'(sel);
        gain_data    = 8'(dat);
        e = cyc + 1;
        if (rst) begin
            for (int i = sb.size() - 1; i >= 0; i--)
                if (sb[i].due >= e) sb.delete(i);
            for (int i = 0; i < 3; i++) m_gain[i] = 64;
            m_acc_edge = -100;
            if (e < MAXE) begin
                exp_busy[e] = 1'b0;
                exp_drop[e] = 1'b0;
                exp_rst[e]  = 1'b1;
            end
        end else begin
            d = e - m_acc_edge;
            was_busy = (d >= 1) && (d <= 4);
            if (sv && !was_busy) begin
                sb.push_back('{val: mix(l, m, h), due: e + 4});
                m_acc_edge = e;
            end
            if (we && sel < 3) m_gain[sel] = dat;
            if (e < MAXE) begin
                exp_busy[e] = ((e - m_acc_edge) >= 0) && ((e - m_acc_edge) <= 3);
                exp_drop[e] = sv && was_busy;
                exp_rst[e]  = 1'b0;
            end
        end
        if (e < MAXE) exp_set[e] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic send(input int l, input int m, input int h);
        drive(0, 1, l, m, h, 0, 0, 0);
    endtask

    task automatic wr(input int sel, input int dat);
        drive(0, 0, 0, 0, 0, 1, sel, dat);
    endtask

    // Monitor: compares DUT outputs against the scoreboard after every edge.
    int hold_val = 0;
    always @(negedge clk) begin
        int k;
        exp_t x;
        k = cyc;
        if (k > 0 && k < MAXE && exp_set[k]) begin
            if (exp_rst[k]) hold_val = 0;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_out_valid", 1, 0);
                end else begin
                    x = sb.pop_front();
                    chk("out_valid_edge", k, x.due);
                    chk("out_value", int'(audio_out), x.val);
                    hold_val = x.val;
                end
            end else if (sb.size() > 0 && sb[0].due <= k) begin
                chk("missing_out_valid", 0, 1);
                void'(sb.pop_front());
            end
            chk("busy", int'(busy), int'(exp_busy[k]));
            chk("sample_drop", int'(sample_drop), int'(exp_drop[k]));
            chk("audio_hold", int'(audio_out), hold_val);
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) m_gain[i] = 64;
        @(posedge clk);
        #1;
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 5, 5, 5, 1, 0, 9);
        idle(1);

        // Unity mix
        send(100, 200, 300);
        idle(5);

        // Low gain x2, large positive sum
        wr(0, 128);
        send(20000, 20000, 0);
        idle(5);

        // Floor rounding on a small negative value
        wr(0, 32);
        send(-1, 0, 0);
        idle(5);

        // Maximum gains on full-scale negative input
        wr(0, 255); wr(1, 255); wr(2, 255);
        send(-32768, -32768, -32768);
        idle(5);
        wr(0, 64); wr(1, 64); wr(2, 64);
        wr(3, 0);

        // Second sample while busy is dropped
        send(1000, -2000, 3000);
        idle(1);
        send(7, 7, 7);
        idle(5);

        // Gain write in the acceptance cycle applies only to the next sample
        drive(0, 1, 111, 222, 333, 1, 1, 0);
        idle(4);
        send(111, 222, 333);
        idle(5);

        // Reset during MAC_MID abandons the sample
        wr(1, 10);
        send(4000, 5000, 6000);
        idle(1);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        send(4000, 5000, 6000);
        idle(5);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bit rst;
            rst = ($urandom_range(0, 99) == 0);
            drive(rst, ($urandom_range(0, 2) == 0),
                  $urandom_range(0, 65535) - 32768,
                  $urandom_range(0, 65535) - 32768,
                  $urandom_range(0, 65535) - 32768,
                  ($urandom_range(0, 5) == 0),
                  $urandom_range(0, 3),
                  $urandom_range(0, 255));
        end
        idle(8);

        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
